// File: rtl/uartprobe_bridge.sv
// Byte-command bridge: UART byte streams to N GPIO banks and a single-beat AXI master.
// Build option UARTPROBE_AUTOINC_EN: post-increment addr by DATA_BYTES after an OKAY AXI access.
module uartprobe_bridge #(
  parameter int          GPIO_BANKS        = 4,
  parameter int          DATA_BYTES        = 4,
  parameter int          TIMEOUT_CYCLES    = 1024,
  parameter logic [31:0] GPO_ON_RESET      = 32'b0,
  parameter logic [31:0] AXI_ADDR_ON_RESET = 32'b0
) (
  input  logic                      clk,
  input  logic                      m_areset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  input  logic                      tx_ready,
  output logic [32*GPIO_BANKS-1:0]  gpo,
  input  logic [32*GPIO_BANKS-1:0]  gpi,
  output logic [31:0]               m_axi_araddr,
  output logic [2:0]                m_axi_arsize,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [8*DATA_BYTES-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [31:0]               m_axi_awaddr,
  output logic [2:0]                m_axi_awsize,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [8*DATA_BYTES-1:0]   m_axi_wdata,
  output logic [DATA_BYTES-1:0]     m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [2:0]                dbg_state
);

  localparam int          DW       = 8 * DATA_BYTES;
  localparam logic [2:0]  AXI_SIZE = (DATA_BYTES == 4) ? 3'd2 : (DATA_BYTES == 2) ? 3'd1 : 3'd0;
  localparam logic [2:0]  NBYTES   = 3'(DATA_BYTES);
  localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_ARG   = 3'd1,
    S_EXEC     = 3'd2,
    S_AXI_REQ  = 3'd3,
    S_AXI_RESP = 3'd4,
    S_TX       = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 op_q, bank_q;
  logic [31:0]                arg_q, addr_q, tmr_q;
  logic [2:0]                 arg_cnt_q, arg_need, cmd_nargs, tx_left_q;
  logic [32*GPIO_BANKS-1:0]   gpo_q;
  logic [39:0]                tx_buf_q;
  logic                       ar_pend_q, aw_pend_q, w_pend_q;
  logic                       rx_fire, tx_fire, cmd_bank_ok, bank_ok;
  logic                       resp_fire, req_done, timed_out, is_axi_wr;
  logic [31:0]                rdata_ext;
  logic [1:0]                 resp_sel;

  assign is_axi_wr     = (op_q == 4'h7);
  assign resp_sel      = is_axi_wr ? m_axi_bresp : m_axi_rresp;
  assign gpo           = gpo_q;
  assign tx_data       = tx_buf_q[39:32];
  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_wdata   = arg_q[DW-1:0];
  assign m_axi_wstrb   = '1;
  assign dbg_state     = state_q;

  always_comb begin
    cmd_bank_ok = ({28'd0, rx_data[3:0]} < 32'(GPIO_BANKS));
    bank_ok     = ({28'd0, bank_q} < 32'(GPIO_BANKS));
    arg_need    = is_axi_wr ? NBYTES : 3'd4;
    rdata_ext   = '0;
    rdata_ext[31 -: DW] = m_axi_rdata;
    case (rx_data[7:4])
      4'h3:    cmd_nargs = cmd_bank_ok ? 3'd4 : 3'd0;
      4'h4:    cmd_nargs = 3'd4;
      4'h7:    cmd_nargs = NBYTES;
      default: cmd_nargs = 3'd0;
    endcase
  end

  // Handshakes: a byte/beat transfers on the rising edge where valid and ready are both high;
  // a raised valid is held, with stable payload, until that edge.
  always_comb begin
    state_d       = state_q;
    rx_ready      = (state_q == S_IDLE) || (state_q == S_RX_ARG);
    tx_valid      = (state_q == S_TX);
    m_axi_arvalid = (state_q == S_AXI_REQ) && ar_pend_q;
    m_axi_awvalid = (state_q == S_AXI_REQ) && aw_pend_q;
    m_axi_wvalid  = (state_q == S_AXI_REQ) && w_pend_q;
    m_axi_rready  = (state_q == S_AXI_RESP) && !is_axi_wr;
    m_axi_bready  = (state_q == S_AXI_RESP) && is_axi_wr;
    rx_fire       = rx_valid && rx_ready;
    tx_fire       = tx_valid && tx_ready;
    resp_fire     = (state_q == S_AXI_RESP) && (is_axi_wr ? m_axi_bvalid : m_axi_rvalid);
    req_done      = !(ar_pend_q && !m_axi_arready) && !(aw_pend_q && !m_axi_awready) &&
                    !(w_pend_q && !m_axi_wready);
    // A response landing in the final cycle still wins over the abort.
    timed_out     = ((state_q == S_AXI_REQ) || (state_q == S_AXI_RESP)) &&
                    (tmr_q == TMR_LAST) && !resp_fire;
    case (state_q)
      S_IDLE:     if (rx_fire) state_d = (cmd_nargs != 3'd0) ? S_RX_ARG : S_EXEC;
      S_RX_ARG:   if (rx_fire && (arg_cnt_q == arg_need - 3'd1)) state_d = S_EXEC;
      S_EXEC:     state_d = ((op_q == 4'h6) || is_axi_wr) ? S_AXI_REQ : S_TX;
      S_AXI_REQ:  if (timed_out) state_d = S_TX; else if (req_done) state_d = S_AXI_RESP;
      S_AXI_RESP: if (timed_out || resp_fire) state_d = S_TX;
      S_TX:       if (tx_fire && (tx_left_q == 3'd1)) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (m_areset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (m_areset) begin
      op_q      <= '0;
      bank_q    <= '0;
      arg_q     <= '0;
      arg_cnt_q <= '0;
      addr_q    <= AXI_ADDR_ON_RESET;
      gpo_q     <= {GPIO_BANKS{GPO_ON_RESET}};
      tx_buf_q  <= '0;
      tx_left_q <= '0;
      tmr_q     <= '0;
      ar_pend_q <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (rx_fire) begin
          op_q      <= rx_data[7:4];
          bank_q    <= rx_data[3:0];
          arg_cnt_q <= '0;
        end
        S_RX_ARG: if (rx_fire) begin
          arg_q     <= {arg_q[23:0], rx_data};
          arg_cnt_q <= arg_cnt_q + 3'd1;
        end
        S_EXEC: begin
          tx_buf_q  <= {8'hEE, 32'h0};
          tx_left_q <= 3'd1;
          tmr_q     <= '0;
          ar_pend_q <= (op_q == 4'h6);
          aw_pend_q <= is_axi_wr;
          w_pend_q  <= is_axi_wr;
          case (op_q)
            4'h1: if (bank_ok) begin
              tx_buf_q  <= {gpi[32*bank_q +: 32], 8'h00};
              tx_left_q <= 3'd4;
            end
            4'h2: if (bank_ok) begin
              tx_buf_q  <= {gpo_q[32*bank_q +: 32], 8'h00};
              tx_left_q <= 3'd4;
            end
            4'h3: if (bank_ok) begin
              gpo_q[32*bank_q +: 32] <= arg_q;
              tx_buf_q               <= 40'h0;
            end
            4'h4: begin
              addr_q   <= arg_q;
              tx_buf_q <= 40'h0;
            end
            4'h5: begin
              tx_buf_q  <= {addr_q, 8'h00};
              tx_left_q <= 3'd4;
            end
            default: ;
          endcase
        end
        S_AXI_REQ, S_AXI_RESP: begin
          tmr_q     <= tmr_q + 32'd1;
          ar_pend_q <= ar_pend_q && !m_axi_arready;
          aw_pend_q <= aw_pend_q && !m_axi_awready;
          w_pend_q  <= w_pend_q && !m_axi_wready;
          tx_left_q <= is_axi_wr ? 3'd1 : 3'd1 + NBYTES;
          if (timed_out) begin
            ar_pend_q <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            tx_buf_q  <= {8'h80, 32'h0};
          end else if (resp_fire) begin
            tx_buf_q <= {6'b0, resp_sel, is_axi_wr ? 32'h0 : rdata_ext};
`ifdef UARTPROBE_AUTOINC_EN
            if (resp_sel == 2'b00) addr_q <= addr_q + 32'(DATA_BYTES);
`endif
          end
        end
        S_TX: if (tx_fire) begin
          tx_buf_q  <= {tx_buf_q[31:0], 8'h00};
          tx_left_q <= tx_left_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uartprobe_bridge.sv
// Directed bench for uartprobe_bridge: byte driver, AXI slave model, tx scoreboard.
module tb_uartprobe_bridge;
  localparam int GB = 4;
  localparam int DB = 4;
  localparam int TO = 16;

  logic            clk, m_areset;
  logic            rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]      rx_data, tx_data;
  logic [32*GB-1:0] gpo, gpi;
  logic [31:0]     m_axi_araddr, m_axi_awaddr;
  logic [2:0]      m_axi_arsize, m_axi_awsize, dbg_state;
  logic            m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic            m_axi_bvalid, m_axi_bready;
  logic [8*DB-1:0] m_axi_rdata, m_axi_wdata;
  logic [DB-1:0]   m_axi_wstrb;
  logic [1:0]      m_axi_rresp, m_axi_bresp;

  uartprobe_bridge #(.GPIO_BANKS(GB), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .m_areset(m_areset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .gpo(gpo), .gpi(gpi),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  int         tx_total = 0;
  logic       tx_stall = 1'b0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (m_areset) begin
      tx_ready  = 1'b1;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, hold_data});
      tx_ready = tx_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        if (tx_total < exp_q.size())
          check($sformatf("tx_byte%0d", tx_total), {56'd0, tx_data}, {56'd0, exp_q[tx_total]});
        tx_total++;
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  // AXI slave model
  int          ar_lat = 0, aw_lat = 0, w_lat = 0;
  logic        ar_hang = 1'b0;
  logic [31:0] rdata_v = '0;
  logic [1:0]  rresp_v = '0, bresp_v = '0;
  int          ar_age, aw_age, w_age, ar_hi_cnt = 0;
  logic        r_pend, b_pend, aw_done, w_done, r_fire, b_fire;
  logic [31:0] got_araddr, got_awaddr, got_wdata;
  logic [2:0]  got_arsize, got_awsize;
  logic [3:0]  got_wstrb;

  always @(negedge clk) begin
    if (m_areset) begin
      r_pend = 0; b_pend = 0; aw_done = 0; w_done = 0; r_fire = 0; b_fire = 0;
      ar_age = 0; aw_age = 0; w_age = 0;
      m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
      m_axi_rvalid = 0; m_axi_bvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
    end else begin
      if (r_fire) r_pend = 0;
      if (b_fire) b_pend = 0;
      if (m_axi_arvalid) ar_hi_cnt++;
      m_axi_arready = m_axi_arvalid && !ar_hang && (ar_age >= ar_lat);
      ar_age = m_axi_arvalid ? ar_age + 1 : 0;
      if (m_axi_arvalid && m_axi_arready) begin
        got_araddr = m_axi_araddr; got_arsize = m_axi_arsize; r_pend = 1;
      end
      m_axi_awready = m_axi_awvalid && (aw_age >= aw_lat);
      aw_age = m_axi_awvalid ? aw_age + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) begin
        got_awaddr = m_axi_awaddr; got_awsize = m_axi_awsize; aw_done = 1;
      end
      m_axi_wready = m_axi_wvalid && (w_age >= w_lat);
      w_age = m_axi_wvalid ? w_age + 1 : 0;
      if (m_axi_wvalid && m_axi_wready) begin
        got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; w_done = 1;
      end
      if (aw_done && w_done) begin b_pend = 1; aw_done = 0; w_done = 0; end
      m_axi_rvalid = r_pend; m_axi_rdata = rdata_v; m_axi_rresp = rresp_v;
      r_fire = m_axi_rvalid && m_axi_rready;
      m_axi_bvalid = b_pend; m_axi_bresp = bresp_v;
      b_fire = m_axi_bvalid && m_axi_bready;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (tx_total != exp_q.size() && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(tx_total), 64'(exp_q.size()));
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] exp_addr;

  initial begin
    m_areset = 1'b1; rx_valid = 1'b0; rx_data = '0; gpi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_gpo_lo", gpo[63:0], 64'd0);
    check("rst_gpo_hi", gpo[127:64], 64'd0);
    check("rst_valids", {61'd0, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 64'd0);
    check("rst_readys", {62'd0, m_axi_rready, m_axi_bready}, 64'd0);
    check("rst_addr", {32'd0, m_axi_araddr}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    m_areset = 1'b0;

    send_byte(8'h22); expect_word(32'h0); drain("drain_gpo_rd");
    check("gpo_zero", gpo[127:64] | gpo[63:0], 64'd0);

    send_byte(8'h31); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    @(negedge clk);
    check("gpo_partial", {32'd0, gpo[63:32]}, 64'd0);
    send_byte(8'hEF); exp_q.push_back(8'h00); drain("drain_gpo_wr");
    check("gpo_bank1", {32'd0, gpo[63:32]}, 64'hDEADBEEF);
    check("gpo_bank0", {32'd0, gpo[31:0]}, 64'd0);
    check("gpo_bank23", gpo[127:64], 64'd0);

    send_byte(8'h21); expect_word(32'hDEADBEEF); drain("drain_gpo_rd1");

    gpi[95:64] = 32'h12345678; gpi[31:0] = 32'hFFFFFFFF;
    send_byte(8'h12); expect_word(32'h12345678); drain("drain_gpi_rd");

    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    exp_q.push_back(8'h00);
    send_byte(8'h50); expect_word(32'h00001000); drain("drain_addr");

    rdata_v = 32'h11223344; rresp_v = 2'b00;
    send_byte(8'h60); exp_q.push_back(8'h00); expect_word(32'h11223344); drain("drain_axi_rd");
    check("araddr", {32'd0, got_araddr}, 64'h1000);
    check("arsize", {61'd0, got_arsize}, 64'd2);

    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    exp_q.push_back(8'h00);
    aw_lat = 3; w_lat = 0; bresp_v = 2'b10;
    send_byte(8'h70); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'h00); send_byte(8'h01);
    exp_q.push_back(8'h02); drain("drain_axi_wr");
    check("wdata", {32'd0, got_wdata}, 64'hCAFE0001);
    check("wstrb", {60'd0, got_wstrb}, 64'hF);
    check("awaddr", {32'd0, got_awaddr}, 64'h1000);
    check("awsize", {61'd0, got_awsize}, 64'd2);
    aw_lat = 0;

    ar_hang = 1'b1;
    begin
      int base;
      base = ar_hi_cnt;
      send_byte(8'h60); exp_q.push_back(8'h80); expect_word(32'h0); drain("drain_timeout");
      check("arvalid_cycles", 64'(ar_hi_cnt - base), 64'd16);
    end
    ar_hang = 1'b0;
    check("post_to_valid", {63'd0, m_axi_arvalid}, 64'd0);

    send_byte(8'h9F); exp_q.push_back(8'hEE);
    send_byte(8'h34); exp_q.push_back(8'hEE);
    send_byte(8'h00); exp_q.push_back(8'hEE);
    send_byte(8'h50); expect_word(32'h00001000); drain("drain_bad_ops");

    rdata_v = 32'hA5A55A5A; rresp_v = 2'b00;
    send_byte(8'h60); exp_q.push_back(8'h00); expect_word(32'hA5A55A5A);
    send_byte(8'h60); exp_q.push_back(8'h00); expect_word(32'hA5A55A5A);
    drain("drain_two_rd");
`ifdef UARTPROBE_AUTOINC_EN
    check("araddr_second", {32'd0, got_araddr}, 64'h1004);
    exp_addr = 32'h1008;
`else
    check("araddr_second", {32'd0, got_araddr}, 64'h1000);
    exp_addr = 32'h1000;
`endif

    tx_stall = 1'b1;
    send_byte(8'h50); expect_word(exp_addr);
    send_byte(8'h21); expect_word(32'hDEADBEEF);
    drain("drain_stall");
    tx_stall = 1'b0;

    send_byte(8'h31); send_byte(8'hAA);
    @(negedge clk);
    m_areset = 1'b1;
    @(negedge clk);
    check("midrst_state", {61'd0, dbg_state}, 64'd0);
    check("midrst_rx_ready", {63'd0, rx_ready}, 64'd1);
    check("midrst_gpo", {32'd0, gpo[63:32]}, 64'd0);
    m_areset = 1'b0;
    send_byte(8'h21); expect_word(32'h0); drain("drain_after_rst");

    check("tx_count", 64'(tx_total), 64'(exp_q.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
